// File: rtl/userio_sampler_pkg.sv
// Shared state encoding and entry sizing for the USERIO capture path.
// Define USERIO_SAMPLER_TIMESTAMP_EN to prefix every entry with a saturating delta timestamp.
package userio_sampler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

`ifdef USERIO_SAMPLER_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   function automatic int entry_width(input int pins_w, input int ts_w);
      return TS_EN ? pins_w + ts_w : pins_w;
   endfunction

endpackage

// File: rtl/userio_sampler_if.sv
// Host-side control and FIFO read bus of the USERIO sampler.
// master = USB register block, slave = sampler.
interface userio_sampler_if
   import userio_sampler_pkg::*;
#(
   parameter int pWIDTH    = 8,
   parameter int pTS_WIDTH = 16
);
   localparam int ENTRY_W = entry_width(pWIDTH, pTS_WIDTH);

   logic [pWIDTH-1:0]  I_mask;
   logic               I_arm;
   logic               I_disarm;
   logic [15:0]        I_capture_count;
   logic               I_fifo_rd;
   logic [ENTRY_W-1:0] O_fifo_dout;
   logic               O_fifo_empty;
   logic               O_overflow;
   logic [1:0]         O_state;
   logic [pWIDTH-1:0]  O_pins;

   modport master (
      output I_mask, I_arm, I_disarm, I_capture_count, I_fifo_rd,
      input  O_fifo_dout, O_fifo_empty, O_overflow, O_state, O_pins
   );

   modport slave (
      input  I_mask, I_arm, I_disarm, I_capture_count, I_fifo_rd,
      output O_fifo_dout, O_fifo_empty, O_overflow, O_state, O_pins
   );

endinterface

// File: rtl/userio_sample_fifo.sv
// FWFT FIFO with flush; head visible combinationally, write/read/flush take effect on the clock edge.
// Write into full is dropped unless a pop happens the same cycle; pop on empty is ignored.
module userio_sample_fifo #(
   parameter int pW          = 8,
   parameter int pDEPTH_LOG2 = 4
) (
   input  logic          usb_clk,
   input  logic          reset_n,
   input  logic          flush_i,
   input  logic          wr_i,
   input  logic [pW-1:0] wr_dat_i,
   input  logic          rd_i,
   output logic [pW-1:0] rd_dat_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int DEPTH = 2 ** pDEPTH_LOG2;

   logic [pDEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
   logic [pW-1:0]        mem_q [DEPTH];
   logic                 do_wr, do_rd;

   // Extra pointer MSB distinguishes full from empty when the indices alias.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[pDEPTH_LOG2] != rd_ptr_q[pDEPTH_LOG2]) &&
                    (wr_ptr_q[pDEPTH_LOG2-1:0] == rd_ptr_q[pDEPTH_LOG2-1:0]);
   assign do_rd   = rd_i && !empty_o;
   assign do_wr   = wr_i && (!full_o || do_rd);

   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + (pDEPTH_LOG2+1)'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + (pDEPTH_LOG2+1)'(1);
      end
   end

   always_ff @(posedge usb_clk) begin
      if (do_wr) mem_q[wr_ptr_q[pDEPTH_LOG2-1:0]] <= wr_dat_i;
   end

   assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[pDEPTH_LOG2-1:0]];

endmodule

// File: rtl/userio_sampler.sv
// USERIO pin-change capture: 2-flop sync, masked edge detect, entries written 2 edges after the pad sample edge.
// Full FIFO with no same-cycle pop drops the entry, sets sticky overflow and stops; optional USERIO_SAMPLER_TIMESTAMP_EN.
module userio_sampler
   import userio_sampler_pkg::*;
#(
   parameter int pWIDTH      = 8,
   parameter int pTS_WIDTH   = 16,
   parameter int pDEPTH_LOG2 = 4
) (
   input  logic              usb_clk,
   input  logic              reset_n,
   input  logic [pWIDTH-1:0] userio_d,
   userio_sampler_if.slave   host
);
   localparam int ENTRY_W = entry_width(pWIDTH, pTS_WIDTH);

   state_e             state_q, state_d;
   logic [pWIDTH-1:0]  sync1_q, sync2_q, prev_q, change;
   logic [15:0]        count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               wr, flush, fifo_full;
   logic [ENTRY_W-1:0] entry;

   // All-ones reset matches the pad pullups so release does not look like an edge.
   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         prev_q  <= '1;
      end else begin
         sync1_q <= userio_d;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign change = (sync2_q ^ prev_q) & host.I_mask;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      wr         = 1'b0;
      flush      = 1'b0;
      if (host.I_disarm) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (host.I_arm) begin
                  state_d    = ST_ARMED;
                  flush      = 1'b1;
                  count_d    = '0;
                  overflow_d = 1'b0;
               end
            end
            ST_ARMED, ST_CAPTURE: begin
               if (|change) begin
                  if (fifo_full && !host.I_fifo_rd) begin
                     overflow_d = 1'b1;
                     state_d    = ST_DONE;
                  end else begin
                     wr      = 1'b1;
                     count_d = (state_q == ST_ARMED) ? 16'd1 : count_q + 16'd1;
                     state_d = (host.I_capture_count != '0 && count_d == host.I_capture_count)
                               ? ST_DONE : ST_CAPTURE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef USERIO_SAMPLER_TIMESTAMP_EN
   logic [pTS_WIDTH-1:0] ts_q, ts_d;

   // Held at zero while armed so the first entry reports 0; reloads to 1 on each write.
   always_comb begin
      ts_d = ts_q;
      if (flush || (state_q == ST_ARMED && !wr)) ts_d = '0;
      else if (wr)                               ts_d = pTS_WIDTH'(1);
      else if (ts_q != '1)                       ts_d = ts_q + pTS_WIDTH'(1);
   end

   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) ts_q <= '0;
      else          ts_q <= ts_d;
   end

   assign entry = {ts_q, sync2_q};
`else
   assign entry = sync2_q;
`endif

   userio_sample_fifo #(
      .pW          (ENTRY_W),
      .pDEPTH_LOG2 (pDEPTH_LOG2)
   ) u_fifo (
      .usb_clk  (usb_clk),
      .reset_n  (reset_n),
      .flush_i  (flush),
      .wr_i     (wr),
      .wr_dat_i (entry),
      .rd_i     (host.I_fifo_rd),
      .rd_dat_o (host.O_fifo_dout),
      .full_o   (fifo_full),
      .empty_o  (host.O_fifo_empty)
   );

   assign host.O_overflow = overflow_q;
   assign host.O_state    = state_q;
   assign host.O_pins     = sync2_q;

endmodule
